clkdiv_monitor: RTL
===================

// Module: clkdiv_monitor
// PURPOSE
//  Receive-side checker for divided clocks produced by the clkDivider family.
//  Samples a divided clock on the fast reference clock and measures each period and high phase.
//  Flags lock after repeated matches to the expected divisor; flags mismatch and stuck clocks.
//  Sits beside any clkDivider instance as a built-in self-check or debug monitor.
// PARAMETERS
//  CNT_W     8   width of the period/high counters; saturates at 2**CNT_W-1
//  EXP_DIV   7   expected divide ratio (>=2, < 2**CNT_W-1)
//  LOCK_CNT  4   consecutive matching periods required before o_locked asserts (>=1)
// PORTS
//  clk         in   1      fast reference clock (the divider's source clock)
//  reset       in   1      synchronous, active-high reset
//  i_div_clk   in   1      divided clock under test
//  i_clear     in   1      clears sticky o_err
//  o_period    out  CNT_W  last measured period, in clk cycles
//  o_high      out  CNT_W  last measured high-phase length, in clk cycles
//  o_valid     out  1      1-cycle pulse: o_period/o_high updated
//  o_locked    out  1      LOCK_CNT consecutive matching periods seen
//  o_err       out  1      sticky: mismatch or stuck clock since last clear/reset
//  o_stuck     out  1      no rising edge within 2**CNT_W-1 cycles
// BEHAVIOUR
//  - One clock, clk; reset is synchronous and active-high. All state is reset to 0; state is ST_WAIT.
//  - Sampling: s = registered i_div_clk, or 2-flop synchronised when the macro is on; s_d = s delayed 1 cycle.
//  - Edge detect: rise = s & ~s_d.
//  - ST_WAIT: counters idle, o_valid=0. On rise -> ST_MEAS with per_cnt<=1, hi_cnt<=1.
//  - ST_MEAS, no rise:
//    - per_cnt increments and saturates at 2**CNT_W-1.
//    - hi_cnt increments only while s=1, also saturating.
//  - ST_MEAS, on rise:
//    - o_period<=per_cnt, o_high<=hi_cnt, o_valid=1 for the next cycle only.
//    - per_cnt<=1, hi_cnt<=1.
//  - Example: an ideal divide-by-7 input gives o_period=7 every 7th cycle.
//  - Match when o_period==EXP_DIV and o_high is in {EXP_DIV/2, (EXP_DIV+1)/2} (integer division).
//    - The range covers sample quantisation of odd 50%-duty dividers.
//  - Match: match_cnt increments, saturating at LOCK_CNT. o_locked=(match_cnt==LOCK_CNT), registered with o_valid.
//  - Mismatch: match_cnt<=0, o_locked<=0, o_err<=1.
//  - Stuck: per_cnt reaches 2**CNT_W-1 in ST_MEAS.
//    - o_stuck<=1, o_err<=1, o_locked<=0, match_cnt<=0; state -> ST_WAIT.
//    - o_stuck clears on the next rise.
//  - Stuck from reset: in ST_WAIT, a stuck input never sets o_stuck. o_locked=0 there is the indication.
//  - The first rise after ST_WAIT never produces o_valid; measurement starts at the second rise.
//  - i_clear and an error in the same cycle: the error wins and o_err stays 1.
//  - Reset mid-period: measurement is discarded with no o_valid; the block resumes from ST_WAIT.
//  - Latency: rise on i_div_clk to o_valid is 3 clk cycles; with the macro on it is 4.
// CONFIGURATION
//  - Macro CLKDIV_MON_SYNC_EN:
//    - Defined: i_div_clk passes a 2-flop synchroniser before s. Use for asynchronous/foreign clocks. Latency +1.
//    - Undefined: single register stage. Use when i_div_clk is derived from clk.
// STRUCTURE
//  - Package clkdiv_pkg:
//    - state enum {ST_WAIT, ST_MEAS};
//    - localparam CNT_MAX = 2**CNT_W-1;
//    - match-window function hi_lo(EXP_DIV)/hi_hi(EXP_DIV).
//  - Sub-module clkdiv_edge_sync:
//    - sampling or synchroniser stage plus s_d register, outputs s and rise;
//    - contains the CLKDIV_MON_SYNC_EN switch.
//  - Top: FSM, counters, compare, lock and error flags.
// TESTING
//  - Drive the clkDivider_by7 output, EXP_DIV=7, LOCK_CNT=4:
//    - o_valid every 7 cycles, o_period=7, o_high in {3,4};
//    - o_locked=1 with the 4th o_valid; o_err=0.
//  - Locked, then one period stretched to 8 -> o_valid with o_period=8, o_locked=0, o_err=1.
//    - Relock after 4 good periods; o_err stays 1 until i_clear.
//  - Hold i_div_clk=0 after lock, CNT_W=8:
//    - 255 cycles after the last rise, o_stuck=1 and o_locked=0;
//    - next rise clears o_stuck, with no o_valid.
//  - Duty fault: period 7, high 1 -> o_err=1, o_locked=0.
//  - i_clear in the same cycle as a mismatch -> o_err remains 1.
//    - i_clear alone on the next cycle -> o_err=0.
//  - Assert reset mid-period while locked:
//    - all outputs 0 the next cycle;
//    - first o_valid comes only after two further rises.
//    - Repeat with CLKDIV_MON_SYNC_EN defined and check +1 latency.

Source files
------------

// File: rtl/clkdiv_pkg.sv
// Shared types and helpers for the divided-clock monitor.
// Holds the FSM state encoding, the default counter ceiling and the
// high-phase match window used to accept quantised 50%-duty dividers.
package clkdiv_pkg;

   // Measurement FSM: waiting for a reference rise, or timing a period.
   typedef enum logic [0:0] {
      ST_WAIT = 1'b0,
      ST_MEAS = 1'b1
   } clkdiv_state_e;

   // Counter ceiling for the default 8-bit counters.
   localparam int CNT_W_DEF = 8;
   localparam int CNT_MAX   = (1 << CNT_W_DEF) - 1;

   // Ceiling of a counter of arbitrary width (all ones).
   function automatic int cnt_max(input int cnt_w);
      return (1 << cnt_w) - 1;
   endfunction

   // Lowest high-phase length accepted for a given divisor.
   function automatic int hi_lo(input int exp_div);
      return exp_div / 2;
   endfunction

   // Highest high-phase length accepted for a given divisor.
   function automatic int hi_hi(input int exp_div);
      return (exp_div + 1) / 2;
   endfunction

endpackage

// File: rtl/clkdiv_edge_sync.sv
// Input stage of the divided-clock monitor.
// Samples div_clk on clk (through a 2-flop synchroniser when the
// CLKDIV_MON_SYNC_EN macro is defined) and produces a registered rising-edge
// strobe together with the sampled level aligned to that strobe.
module clkdiv_edge_sync
   import clkdiv_pkg::*;
(
   input  logic clk,
   input  logic reset,
   input  logic div_clk,
   output logic samp,
   output logic rise
);

   logic samp_in_s;
   logic samp_r;
   logic samp_d_r;
   logic rise_r;

`ifdef CLKDIV_MON_SYNC_EN
   logic meta_r;

   // First synchroniser flop; this one is allowed to go metastable.
   always_ff @(posedge clk) begin
      if (reset) begin
         meta_r <= 1'b0;
      end else begin
         meta_r <= div_clk;
      end
   end

   assign samp_in_s = meta_r;
`else
   assign samp_in_s = div_clk;
`endif

   // Sample the level, keep its one-cycle history and register the rise strobe.
   always_ff @(posedge clk) begin
      if (reset) begin
         samp_r   <= 1'b0;
         samp_d_r <= 1'b0;
         rise_r   <= 1'b0;
      end else begin
         samp_r   <= samp_in_s;
         samp_d_r <= samp_r;
         rise_r   <= samp_r & ~samp_d_r;
      end
   end

   // samp_d_r holds the level of the same cycle that rise_r describes.
   assign samp = samp_d_r;
   assign rise = rise_r;

endmodule

// File: rtl/clkdiv_monitor.sv
// Receive-side checker for divided clocks.
// Measures every period and high phase of i_div_clk in clk cycles, declares
// lock after LOCK_CNT consecutive periods matching EXP_DIV, and raises a
// sticky error on any mismatch or on a stuck input.
// Optional macro CLKDIV_MON_SYNC_EN adds a 2-flop synchroniser on i_div_clk
// (one extra cycle of latency) for clocks not derived from clk.
module clkdiv_monitor
   import clkdiv_pkg::*;
#(
   parameter int CNT_W    = 8,
   parameter int EXP_DIV  = 7,
   parameter int LOCK_CNT = 4
)
(
   input  logic             clk,
   input  logic             reset,
   input  logic             i_div_clk,
   input  logic             i_clear,
   output logic [CNT_W-1:0] o_period,
   output logic [CNT_W-1:0] o_high,
   output logic             o_valid,
   output logic             o_locked,
   output logic             o_err,
   output logic             o_stuck
);

   localparam int MC_W = $clog2(LOCK_CNT + 1);

   localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(cnt_max(CNT_W));
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(32'd1);
   localparam logic [CNT_W-1:0] EXP_L   = CNT_W'(EXP_DIV);
   localparam logic [CNT_W-1:0] HI_LO_L = CNT_W'(hi_lo(EXP_DIV));
   localparam logic [CNT_W-1:0] HI_HI_L = CNT_W'(hi_hi(EXP_DIV));
   localparam logic [MC_W-1:0]  MC_ONE  = MC_W'(32'd1);
   localparam logic [MC_W-1:0]  LOCK_L  = MC_W'(LOCK_CNT);

   logic             samp_s;
   logic             rise_s;
   logic             match_hit_s;
   logic             err_set_s;

   clkdiv_state_e    state_r;
   clkdiv_state_e    state_s;
   logic [CNT_W-1:0] per_cnt_r;
   logic [CNT_W-1:0] per_cnt_s;
   logic [CNT_W-1:0] hi_cnt_r;
   logic [CNT_W-1:0] hi_cnt_s;
   logic [MC_W-1:0]  match_cnt_r;
   logic [MC_W-1:0]  match_cnt_s;
   logic [CNT_W-1:0] period_r;
   logic [CNT_W-1:0] period_s;
   logic [CNT_W-1:0] high_r;
   logic [CNT_W-1:0] high_s;
   logic             valid_r;
   logic             valid_s;
   logic             locked_r;
   logic             locked_s;
   logic             err_r;
   logic             err_s;
   logic             stuck_r;
   logic             stuck_s;

   clkdiv_edge_sync u_edge_sync (
      .clk     (clk),
      .reset   (reset),
      .div_clk (i_div_clk),
      .samp    (samp_s),
      .rise    (rise_s)
   );

   // A finished period matches when its length is exact and its high phase
   // falls inside the window that absorbs odd-divisor quantisation.
   assign match_hit_s = (per_cnt_r == EXP_L) &&
                        (hi_cnt_r >= HI_LO_L) &&
                        (hi_cnt_r <= HI_HI_L);

   // Next-state and next-output logic for the measurement FSM.
   always_comb begin
      state_s     = state_r;
      per_cnt_s   = per_cnt_r;
      hi_cnt_s    = hi_cnt_r;
      match_cnt_s = match_cnt_r;
      period_s    = period_r;
      high_s      = high_r;
      valid_s     = 1'b0;
      locked_s    = locked_r;
      stuck_s     = stuck_r;
      err_set_s   = 1'b0;

      case (state_r)
         ST_WAIT: begin
            // First rise only opens a measurement; nothing is reported yet.
            if (rise_s) begin
               state_s   = ST_MEAS;
               per_cnt_s = CNT_ONE;
               hi_cnt_s  = CNT_ONE;
               stuck_s   = 1'b0;
            end else begin
               state_s   = ST_WAIT;
            end
         end
         ST_MEAS: begin
            if (rise_s) begin
               period_s  = per_cnt_r;
               high_s    = hi_cnt_r;
               valid_s   = 1'b1;
               per_cnt_s = CNT_ONE;
               hi_cnt_s  = CNT_ONE;
               if (match_hit_s) begin
                  if (match_cnt_r == LOCK_L) begin
                     match_cnt_s = LOCK_L;
                  end else begin
                     match_cnt_s = match_cnt_r + MC_ONE;
                  end
                  locked_s = (match_cnt_s == LOCK_L);
               end else begin
                  match_cnt_s = '0;
                  locked_s    = 1'b0;
                  err_set_s   = 1'b1;
               end
            end else if (per_cnt_r == CNT_SAT) begin
               // No rise for a full counter span: the clock is stuck.
               stuck_s     = 1'b1;
               err_set_s   = 1'b1;
               locked_s    = 1'b0;
               match_cnt_s = '0;
               state_s     = ST_WAIT;
            end else begin
               // per_cnt_r is below CNT_SAT here, so the increment cannot wrap.
               per_cnt_s = per_cnt_r + CNT_ONE;
               if (samp_s && (hi_cnt_r != CNT_SAT)) begin
                  hi_cnt_s = hi_cnt_r + CNT_ONE;
               end else begin
                  hi_cnt_s = hi_cnt_r;
               end
            end
         end
         default: begin
            state_s = ST_WAIT;
         end
      endcase

      // A new error always beats a clear requested in the same cycle.
      if (err_set_s) begin
         err_s = 1'b1;
      end else if (i_clear) begin
         err_s = 1'b0;
      end else begin
         err_s = err_r;
      end
   end

   // State, counters and output registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r     <= ST_WAIT;
         per_cnt_r   <= '0;
         hi_cnt_r    <= '0;
         match_cnt_r <= '0;
         period_r    <= '0;
         high_r      <= '0;
         valid_r     <= 1'b0;
         locked_r    <= 1'b0;
         err_r       <= 1'b0;
         stuck_r     <= 1'b0;
      end else begin
         state_r     <= state_s;
         per_cnt_r   <= per_cnt_s;
         hi_cnt_r    <= hi_cnt_s;
         match_cnt_r <= match_cnt_s;
         period_r    <= period_s;
         high_r      <= high_s;
         valid_r     <= valid_s;
         locked_r    <= locked_s;
         err_r       <= err_s;
         stuck_r     <= stuck_s;
      end
   end

   assign o_period = period_r;
   assign o_high   = high_r;
   assign o_valid  = valid_r;
   assign o_locked = locked_r;
   assign o_err    = err_r;
   assign o_stuck  = stuck_r;

endmodule
